ioctl_word_writer: RTL and testbench
====================================

Name: ioctl_word_writer

Overview:
- Sits directly downstream of the APF data I/O block, in the clk_memory domain.
- Consumes its byte-wide ioctl write stream (download flag, slot index, wr strobe, address, data) for one selected slot.
- Packs bytes into 16-bit little-endian words with byte enables and buffers them in a small FIFO.
- Issues them to the SDRAM/BRAM controller over a req/ack handshake, and reports loaded size and completion.

Parameters:
AW, 27, byte address width; must match the upstream data I/O block.
SLOT, 0, ioctl_index value accepted; writes for other indices are ignored.
DEPTH, 8, FIFO depth in words; power of two, minimum 2.
BASE, 0, word-address offset added to every outgoing mem_addr (AW-1 bits, wraps modulo 2^(AW-1)).

Ports:
clk_memory  in  1  memory clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
ioctl_download  in  1  active-download level from data I/O (already synchronised).
ioctl_index  in  16  slot index of the current download.
ioctl_wr  in  1  one-cycle byte write strobe.
ioctl_addr  in  AW  byte address.
ioctl_data  in  8  byte data.
mem_req  out  1  write request, held until acked.
mem_ack  in  1  one-cycle acceptance from the memory controller.
mem_addr  out  AW-1  word address (ioctl_addr[AW-1:1] + BASE).
mem_data  out  16  word data.
mem_be  out  2  byte enables; bit0 = data[7:0].
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse when the download has fully drained.
load_size  out  AW  highest accepted byte address + 1.
overflow  out  1  sticky; set when a word was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FIFO empty; pending word invalid; state IDLE.
- Reset mid-operation: mem_req drops on the next edge, and any in-flight word is discarded.
- Accept condition: ioctl_wr && ioctl_download && ioctl_index==SLOT.
- Byte lane: ioctl_addr[0]=0 goes to the low lane; ioctl_addr[0]=1 goes to the high lane.
- Pending word register holds {word addr, data, be}. On an accepted byte:
  - If pending is valid, the word address matches and the target lane is not yet set: merge the byte into pending.
  - Otherwise: push the old pending word to the FIFO and start a new pending word with this byte.
- When a merge makes be==2'b11, push the merged word the same edge and clear pending.
- Latency: for an accepted byte completing a word at edge N, with the FIFO empty and no request outstanding, mem_req is high after edge N+1.
- Handshake:
  - mem_req, mem_addr, mem_data and mem_be are registered and stable while mem_req=1.
  - On mem_ack=1 the head entry is popped; mem_req may re-assert on the following edge if the FIFO is non-empty.
  - mem_ack while mem_req=0 is ignored.
- FIFO boundaries:
  - A push and a pop on the same edge are both honoured, even when the FIFO is full.
  - A push when full with no pop drops the word and sets overflow. overflow clears only on reset.
- load_size:
  - Cleared on the download rising edge (qualified by SLOT).
  - Updated to max(load_size, ioctl_addr+1) on each accepted byte.
  - Saturates at 2^AW-1.
- State machine:
  - IDLE -> LOAD on ioctl_download rise with ioctl_index==SLOT.
  - LOAD -> FLUSH on ioctl_download fall.
  - FLUSH (1 cycle): push pending if valid (partial be allowed), then go to DRAIN.
  - DRAIN -> DONE when the FIFO is empty and mem_req=0.
  - DONE: done=1 for one cycle, then IDLE.
  - A download rise during DRAIN or DONE goes to LOAD; the remaining FIFO contents are still written and done is not pulsed.
- Download rise for another index: stay in IDLE.

Optional Feature:
- Macro IOCTL_WORD_BYTESWAP_EN.
- Defined: lane mapping is inverted (addr[0]=0 to high byte, big-endian cores), and mem_be bit mapping swaps to match.
- Not defined: little-endian mapping as described in Behaviour.

Decomposition:
- Package ioctl_writer_pkg:
  - state enum {IDLE, LOAD, FLUSH, DRAIN, DONE};
  - packed struct mem_word_t {addr, data[15:0], be[1:0]}, parameterised by AW via a localparam width;
  - lane constants.
- Sub-module ioctl_word_fifo: synchronous FIFO of mem_word_t with push/pop/full/empty and simultaneous push-pop when full.

Test Plan:
- Download slot 0, bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3 -> two writes: (addr 0, 0x2211, be 11), (addr 1, 0x4433, be 11); load_size=4; done pulses once.
- Odd-length download of 3 bytes ending with 0x55@2 -> final write (addr 1, 0x0055, be 01) issued in FLUSH/DRAIN, then done.
- Hold mem_ack low while streaming 20 words with DEPTH=8 -> overflow=1, exactly 9 words written (8 FIFO + 1 in flight), none corrupted.
- ioctl_index=3 with SLOT=0 -> no mem_req, load_size unchanged, busy stays 0.
- Assert reset while mem_req=1 mid-DRAIN -> next cycle mem_req=0, busy=0, done never pulses; a new download then works normally.
- With IOCTL_WORD_BYTESWAP_EN defined, 0x11@0, 0x22@1 -> mem_data=0x1122, be 11.

Source files
------------

// File: rtl/ioctl_writer_pkg.sv
// Shared types and lane constants for the ioctl word writer.
// Build macro IOCTL_WORD_BYTESWAP_EN selects big-endian byte-lane mapping.
package ioctl_writer_pkg;

  localparam int unsigned DefAw     = 27;
  localparam int unsigned DefWordAw = DefAw - 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StDrain,
    StDone
  } wr_state_e;

  typedef struct packed {
    logic [DefWordAw-1:0] addr;
    logic [15:0]          data;
    logic [1:0]           be;
  } mem_word_t;

  // Lane 1 is data[15:8] / be[1].
  localparam logic LaneHi = 1'b1;

`ifdef IOCTL_WORD_BYTESWAP_EN
  localparam logic LaneSwap = 1'b1;
`else
  localparam logic LaneSwap = 1'b0;
`endif

  function automatic logic byte_lane(input logic addr_lsb);
    return addr_lsb ^ LaneSwap;
  endfunction

endpackage

// File: rtl/ioctl_word_writer_if.sv
// Bundle of the ioctl byte stream, memory write handshake and status signals.
// slave is the writer's view; master is the surrounding system's view.
interface ioctl_word_writer_if #(
  parameter int unsigned AW = 27
);
  logic          ioctl_download;
  logic [15:0]   ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_data;
  logic [1:0]    mem_be;
  logic          busy;
  logic          done;
  logic [AW-1:0] load_size;
  logic          overflow;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    output mem_req, mem_addr, mem_data, mem_be, busy, done, load_size, overflow
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    input  mem_req, mem_addr, mem_data, mem_be, busy, done, load_size, overflow
  );
endinterface

// File: rtl/ioctl_word_fifo.sv
// Synchronous FIFO of packed memory words; push and pop on one edge are both
// honoured, including when full.
module ioctl_word_fifo
  import ioctl_writer_pkg::*;
#(
  parameter type         entry_t = mem_word_t,
  parameter int unsigned DEPTH   = 8
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output entry_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned   PtrW   = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

  logic [PtrW:0] r_wr_ptr;
  logic [PtrW:0] r_rd_ptr;
  entry_t        r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                     (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[PtrW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PtrW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ioctl_word_writer.sv
// Packs the ioctl byte stream of one slot into 16-bit words and writes them to memory.
// Build macro IOCTL_WORD_BYTESWAP_EN (in ioctl_writer_pkg) swaps the byte lanes.
module ioctl_word_writer
  import ioctl_writer_pkg::*;
#(
  parameter int unsigned AW    = 27,
  parameter int unsigned SLOT  = 0,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BASE  = 0
) (
  input logic                clk_memory,
  input logic                reset,
  ioctl_word_writer_if.slave bus
);

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
  } word_t;

  localparam logic [AW-2:0] BaseW = (AW-1)'(BASE);
  localparam logic [15:0]   SlotW = 16'(SLOT);

  wr_state_e     r_state;
  wr_state_e     w_state_next;
  logic          r_dl_prev;
  word_t         r_pend;
  logic          r_pend_valid;
  logic          r_mem_req;
  logic [AW-2:0] r_mem_addr;
  logic [15:0]   r_mem_data;
  logic [1:0]    r_mem_be;
  logic [AW-1:0] r_load_size;
  logic          r_overflow;

  logic          w_slot;
  logic          w_start;
  logic          w_fall;
  logic          w_accept;
  logic          w_lane_hi;
  logic [1:0]    w_lane_be;
  logic [15:0]   w_lane_data;
  logic [AW-2:0] w_byte_waddr;
  logic          w_merge;
  word_t         w_pend_next;
  logic          w_pend_valid_next;
  word_t         w_push_word;
  logic          w_push;
  logic          w_pop;
  word_t         w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [AW:0]   w_addr_inc;
  logic [AW-1:0] w_byte_size;

  assign w_slot   = (bus.ioctl_index == SlotW);
  assign w_start  = bus.ioctl_download && !r_dl_prev && w_slot;
  assign w_fall   = !bus.ioctl_download && r_dl_prev;
  assign w_accept = bus.ioctl_wr && bus.ioctl_download && w_slot;

  assign w_lane_hi    = (byte_lane(bus.ioctl_addr[0]) == LaneHi);
  assign w_lane_be    = w_lane_hi ? 2'b10 : 2'b01;
  assign w_lane_data  = w_lane_hi ? {bus.ioctl_data, 8'h00} : {8'h00, bus.ioctl_data};
  assign w_byte_waddr = bus.ioctl_addr[AW-1:1];
  assign w_merge      = r_pend_valid && (r_pend.addr == w_byte_waddr) &&
                        ((r_pend.be & w_lane_be) == 2'b00);

  // A valid pending word only ever holds one byte, so a merge always completes it.
  always_comb begin
    w_pend_next       = r_pend;
    w_pend_valid_next = r_pend_valid;
    w_push            = 1'b0;
    w_push_word       = r_pend;
    if (w_accept) begin
      if (w_merge) begin
        w_push            = 1'b1;
        w_push_word.data  = r_pend.data | w_lane_data;
        w_push_word.be    = r_pend.be | w_lane_be;
        w_pend_valid_next = 1'b0;
      end else begin
        w_push            = r_pend_valid;
        w_pend_next.addr  = w_byte_waddr;
        w_pend_next.data  = w_lane_data;
        w_pend_next.be    = w_lane_be;
        w_pend_valid_next = 1'b1;
      end
    end else if (r_state == StFlush && r_pend_valid) begin
      w_push            = 1'b1;
      w_pend_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_dl_prev    <= 1'b0;
    end else begin
      r_pend       <= w_pend_next;
      r_pend_valid <= w_pend_valid_next;
      r_dl_prev    <= bus.ioctl_download;
    end
  end

  ioctl_word_fifo #(
    .entry_t (word_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .i_clk   (clk_memory),
    .i_reset (reset),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // The output register is the in-flight slot; it refills as soon as it is acked.
  assign w_pop = !w_fifo_empty && (!r_mem_req || bus.mem_ack);

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_be   <= '0;
    end else if (w_pop) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= w_fifo_head.addr + BaseW;
      r_mem_data <= w_fifo_head.data;
      r_mem_be   <= w_fifo_head.be;
    end else if (bus.mem_ack) begin
      r_mem_req  <= 1'b0;
    end
  end

  assign w_addr_inc  = {1'b0, bus.ioctl_addr} + {{AW{1'b0}}, 1'b1};
  assign w_byte_size = w_addr_inc[AW] ? '1 : w_addr_inc[AW-1:0];

  always_ff @(posedge clk_memory) begin
    if (reset) begin
      r_load_size <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_start) begin
        r_load_size <= w_accept ? w_byte_size : '0;
      end else if (w_accept && (w_byte_size > r_load_size)) begin
        r_load_size <= w_byte_size;
      end
      if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_memory) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StLoad;
      StLoad:  if (w_fall) w_state_next = StFlush;
      StFlush: w_state_next = w_start ? StLoad : StDrain;
      StDrain: begin
        if (w_start)                         w_state_next = StLoad;
        else if (w_fifo_empty && !r_mem_req) w_state_next = StDone;
      end
      StDone:  w_state_next = w_start ? StLoad : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state != StIdle);
    bus.done = (r_state == StDone) && !w_start;
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_be    = r_mem_be;
  assign bus.load_size = r_load_size;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_ioctl_word_writer.sv
// Directed/randomised bench for ioctl_word_writer against a byte-map reference model.
module tb_ioctl_word_writer;

  localparam int unsigned AW    = 27;
  localparam int unsigned SLOT  = 0;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BASE  = 0;
`ifdef IOCTL_WORD_BYTESWAP_EN
  localparam int SWAP = 1;
`else
  localparam int SWAP = 0;
`endif

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
  } wrec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ioctl_word_writer_if #(.AW(AW)) mif ();

  ioctl_word_writer #(
    .AW    (AW),
    .SLOT  (SLOT),
    .DEPTH (DEPTH),
    .BASE  (BASE)
  ) dut (
    .clk_memory (clk),
    .reset      (reset),
    .bus        (mif)
  );

  int checks = 0;
  int failures = 0;
  int ack_mode = 0;  // 0: never ack, 1: random ack of requests, 2: ack held high
  wrec_t got_q[$];
  wrec_t exp_q[$];
  logic [7:0] bytes_q[$];

  // Memory controller model: records each word at the moment it is acked.
  initial begin : responder
    wrec_t w;
    mif.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_mode == 1 && mif.mem_req === 1'b1 && $urandom_range(0, 2) != 0) begin
        w.addr = mif.mem_addr;
        w.data = mif.mem_data;
        w.be   = mif.mem_be;
        got_q.push_back(w);
        mif.mem_ack = 1'b1;
      end else begin
        mif.mem_ack = (ack_mode == 2);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input logic [15:0] idx);
    mif.ioctl_index    = idx;
    mif.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    mif.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    mif.ioctl_addr = AW'(a);
    mif.ioctl_data = d;
    mif.ioctl_wr   = 1'b1;
    tick();
    mif.ioctl_wr   = 1'b0;
  endtask

  // Expected words: every word address touched by [start, start+len), ascending.
  task automatic build_exp(input int start, input int len);
    wrec_t w;
    int a;
    int lane;
    exp_q.delete();
    for (int wa = start / 2; wa <= (start + len - 1) / 2; wa++) begin
      w.addr = (AW-1)'(wa + BASE);
      w.data = '0;
      w.be   = '0;
      for (int b = 0; b < 2; b++) begin
        a = 2 * wa + b;
        if (a >= start && a < start + len) begin
          lane = b ^ SWAP;
          w.data[8*lane +: 8] = bytes_q[a - start];
          w.be[lane] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic run_download(input int start, input int len, input bit gaps);
    bytes_q.delete();
    for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    start_dl(16'(SLOT));
    for (int i = 0; i < len; i++) begin
      wr_byte(start + i, bytes_q[i]);
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    end_dl();
  endtask

  task automatic wait_done(input string tag);
    int n_done = 0;
    int cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      tick();
      cyc++;
      if (mif.done === 1'b1) n_done++;
    end
    repeat (4) begin
      tick();
      if (mif.done === 1'b1) n_done++;
    end
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    check({tag, "_busy_after"}, 64'(mif.busy), 64'd0);
  endtask

  task automatic cmp_words(input string tag, input int n);
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin : stim
    int st;
    int ln;
    int seen_req;
    int seen_busy;
    int n_done;
    logic [AW-1:0] prev_size;

    mif.ioctl_download = 1'b0;
    mif.ioctl_index    = '0;
    mif.ioctl_wr       = 1'b0;
    mif.ioctl_addr     = '0;
    mif.ioctl_data     = '0;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_mem_req", 64'(mif.mem_req), 64'd0);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    check("rst_load_size", 64'(mif.load_size), 64'd0);
    check("rst_overflow", 64'(mif.overflow), 64'd0);
    check("rst_mem_data", 64'(mif.mem_data), 64'd0);
    reset = 1'b0;
    tick();

    ack_mode = 2;
    repeat (3) tick();
    check("spurious_ack_req", 64'(mif.mem_req), 64'd0);
    check("spurious_ack_busy", 64'(mif.busy), 64'd0);
    ack_mode = 0;
    tick();

    // Four-byte download, first word latency checked with acks withheld
    got_q.delete();
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_exp(0, 4);
    start_dl(16'(SLOT));
    check("t1_busy", 64'(mif.busy), 64'd1);
    wr_byte(0, 8'h11);
    wr_byte(1, 8'h22);
    check("t1_req_edge_n", 64'(mif.mem_req), 64'd0);
    tick();
    check("t1_req_edge_n1", 64'(mif.mem_req), 64'd1);
    check("t1_addr", 64'(mif.mem_addr), 64'(BASE));
    check("t1_data", 64'(mif.mem_data), (SWAP != 0) ? 64'h1122 : 64'h2211);
    check("t1_be", 64'(mif.mem_be), 64'd3);
    wr_byte(2, 8'h33);
    wr_byte(3, 8'h44);
    end_dl();
    check("t1_load_size", 64'(mif.load_size), 64'd4);
    ack_mode = 1;
    wait_done("t1");
    cmp_words("t1", 2);

    // Odd length: final half word goes out during FLUSH/DRAIN
    got_q.delete();
    bytes_q = '{8'hA0, 8'hA1, 8'h55};
    build_exp(0, 3);
    start_dl(16'(SLOT));
    wr_byte(0, 8'hA0);
    wr_byte(1, 8'hA1);
    wr_byte(2, 8'h55);
    end_dl();
    wait_done("t2");
    cmp_words("t2", 2);
    check("t2_last_data", 64'(exp_q[1].data), (SWAP != 0) ? 64'h5500 : 64'h0055);
    check("t2_load_size", 64'(mif.load_size), 64'd3);

    // Random downloads with random start alignment, length, gaps and ack timing
    for (int it = 0; it < 6; it++) begin
      got_q.delete();
      st = $urandom_range(0, 60);
      ln = $urandom_range(1, 14);
      run_download(st, ln, 1'b1);
      check($sformatf("r%0d_load_size", it), 64'(mif.load_size), 64'(st + ln));
      build_exp(st, ln);
      wait_done($sformatf("r%0d", it));
      cmp_words($sformatf("r%0d", it), exp_q.size());
    end

    // Download for a different slot is ignored entirely
    prev_size = mif.load_size;
    got_q.delete();
    seen_req = 0;
    seen_busy = 0;
    start_dl(16'd3);
    for (int i = 0; i < 6; i++) begin
      wr_byte(i, 8'(i + 1));
      if (mif.mem_req === 1'b1) seen_req++;
      if (mif.busy === 1'b1) seen_busy++;
    end
    end_dl();
    repeat (6) begin
      tick();
      if (mif.mem_req === 1'b1) seen_req++;
      if (mif.busy === 1'b1) seen_busy++;
    end
    check("slot3_req_seen", 64'(seen_req), 64'd0);
    check("slot3_busy_seen", 64'(seen_busy), 64'd0);
    check("slot3_load_size", 64'(mif.load_size), 64'(prev_size));
    check("slot3_load_size_cleared_on_rise", 64'(prev_size == 0), 64'd0);

    // Overflow: 20 words with no acks; 1 in flight + DEPTH buffered survive
    ack_mode = 0;
    got_q.delete();
    bytes_q.delete();
    for (int i = 0; i < 40; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    start_dl(16'(SLOT));
    check("ovf_size_cleared", 64'(mif.load_size), 64'd0);
    for (int i = 0; i < 40; i++) begin
      wr_byte(i, bytes_q[i]);
      if (i == 17) check("ovf_not_yet", 64'(mif.overflow), 64'd0);
    end
    check("ovf_set", 64'(mif.overflow), 64'd1);
    end_dl();
    build_exp(0, 40);
    ack_mode = 1;
    wait_done("ovf");
    cmp_words("ovf", DEPTH + 1);
    check("ovf_sticky", 64'(mif.overflow), 64'd1);

    // Reset while a request is pending in DRAIN
    ack_mode = 0;
    got_q.delete();
    run_download(0, 6, 1'b0);
    tick();
    tick();
    check("rstd_req_before", 64'(mif.mem_req), 64'd1);
    check("rstd_busy_before", 64'(mif.busy), 64'd1);
    reset = 1'b1;
    tick();
    check("rstd_req_after", 64'(mif.mem_req), 64'd0);
    check("rstd_busy_after", 64'(mif.busy), 64'd0);
    check("rstd_overflow_after", 64'(mif.overflow), 64'd0);
    reset = 1'b0;
    ack_mode = 1;
    n_done = 0;
    repeat (10) begin
      tick();
      if (mif.done === 1'b1) n_done++;
    end
    check("rstd_no_done", 64'(n_done), 64'd0);
    check("rstd_no_writes", 64'(got_q.size()), 64'd0);

    got_q.delete();
    st = $urandom_range(0, 20);
    ln = $urandom_range(2, 10);
    run_download(st, ln, 1'b1);
    build_exp(st, ln);
    wait_done("post_rst");
    cmp_words("post_rst", exp_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
